hazard_ctrl: RTL and testbench

- Producer of the `Stall` input consumed by the main decoder.
- Owns all pipeline hold, flush and freeze decisions for the 5-stage RV32I core. It does not decode instructions.
- Keeps a shadow record of the instructions in EX and MEM.
- From that record it detects load-use hazards, sequences control-flow redirect flushes, and freezes the pipe while data memory is not ready, with a timeout.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_perf_cnt.sv | 30 +++
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and the decoder.
package hazard_pkg;

   // Shadow slots hold register indices at this width; REG_AW must not exceed it.
   localparam int unsigned HZ_RD_W = 8;

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      MEM_WAIT
   } hz_state_t;

   typedef struct packed {
      logic               v;
      logic [HZ_RD_W-1:0] rd;
      logic               load;
      logic               wr;
      logic               mem;
   } shadow_slot_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter; clears on reset and holds at all-ones.
module hazard_perf_cnt #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hold/flush/freeze controller for the 5-stage RV32I core.
// Define HAZARD_PERF_EN to add saturating stall/flush/freeze event counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW           = 5,
   parameter int unsigned REDIRECT_PENALTY = 1,
   parameter int unsigned MEM_TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_load,
   input  logic              id_mem,
   input  logic              ex_redirect,
   input  logic              dmem_ready,
   output logic              Stall,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              freeze,
   output logic              mem_err
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_flush_cnt,
   output logic [31:0]       perf_freeze_cnt
`endif
);

   localparam logic [2:0] PEN_RELOAD = 3'(REDIRECT_PENALTY - 1);
   localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

   hz_state_t    state_q, state_d;
   shadow_slot_t ex_q, ex_d, mem_q, mem_d, id_slot;
   logic [2:0]   flush_cnt_q, flush_cnt_d;
   logic [7:0]   wait_cnt_q, wait_cnt_d;
   logic         mem_busy, load_use, flush;

   assign id_slot = '{v:    id_valid,
                      rd:   HZ_RD_W'(id_rd),
                      load: id_load,
                      wr:   id_reg_write,
                      mem:  id_mem};

   assign mem_busy = mem_q.v & mem_q.mem & ~dmem_ready;

   assign load_use = id_valid & ex_q.v & ex_q.load & (ex_q.rd != '0) &
                     ((id_use_rs1 & (HZ_RD_W'(id_rs1) == ex_q.rd)) |
                      (id_use_rs2 & (HZ_RD_W'(id_rs2) == ex_q.rd)));

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      wait_cnt_d  = '0;
      ex_d        = ex_q;
      mem_d       = mem_q;
      Stall       = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      flush       = 1'b0;
      freeze      = 1'b0;
      mem_err     = 1'b0;

      // Freezing is driven by the MEM slot in any state, so a wait always pre-empts a flush.
      if (mem_busy) begin
         freeze     = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         if (wait_cnt_q == WAIT_LAST) begin
            mem_err  = 1'b1;
            mem_d.v  = 1'b0;
            state_d  = RUN;
         end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            state_d    = MEM_WAIT;
         end
      end else begin
         if (ex_redirect) begin
            flush = 1'b1;
            if (REDIRECT_PENALTY > 1) begin
               flush_cnt_d = PEN_RELOAD;
               state_d     = FLUSH;
            end else begin
               state_d = RUN;
            end
         end else if (state_q == FLUSH) begin
            flush       = 1'b1;
            flush_cnt_d = flush_cnt_q - 3'd1;
            state_d     = (flush_cnt_q <= 3'd1) ? RUN : FLUSH;
         end else begin
            state_d = RUN;
            if (load_use) begin
               Stall      = 1'b1;
               pc_write   = 1'b0;
               ifid_write = 1'b0;
            end
         end
         mem_d = ex_q;
         ex_d  = (Stall || flush) ? '0 : id_slot;
      end
   end

   assign ifid_flush = flush;
   assign idex_flush = flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RUN;
         ex_q        <= '0;
         mem_q       <= '0;
         flush_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         flush_cnt_q <= flush_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   hazard_perf_cnt #(.W(32)) u_perf_stall (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .inc_i  (Stall),
      .cnt_o  (perf_stall_cnt)
   );

   hazard_perf_cnt #(.W(32)) u_perf_flush (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .inc_i  (ifid_flush),
      .cnt_o  (perf_flush_cnt)
   );

   hazard_perf_cnt #(.W(32)) u_perf_freeze (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .inc_i  (freeze),
      .cnt_o  (perf_freeze_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (REDIRECT_PENALTY=2, MEM_TIMEOUT=4).
module tb_hazard_ctrl;

   // Output vector order: {Stall, pc_write, ifid_write, ifid_flush, idex_flush, freeze, mem_err}
   localparam logic [6:0] NORM  = 7'b0110000;
   localparam logic [6:0] STALL = 7'b1000000;
   localparam logic [6:0] FLSH  = 7'b0111100;
   localparam logic [6:0] FRZ   = 7'b0000010;
   localparam logic [6:0] FERR  = 7'b0000011;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_load, id_mem;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       ex_redirect, dmem_ready;
   logic       Stall, pc_write, ifid_write, ifid_flush, idex_flush, freeze, mem_err;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .REG_AW           (5),
      .REDIRECT_PENALTY (2),
      .MEM_TIMEOUT      (4)
   ) dut (
`ifdef HAZARD_PERF_EN
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_flush_cnt  (perf_flush_cnt),
      .perf_freeze_cnt (perf_freeze_cnt),
`endif
      .clk          (clk),
      .reset_n      (reset_n),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_load      (id_load),
      .id_mem       (id_mem),
      .ex_redirect  (ex_redirect),
      .dmem_ready   (dmem_ready),
      .Stall        (Stall),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .freeze       (freeze),
      .mem_err      (mem_err)
   );

   task automatic chk(input string tag, input logic [6:0] exp);
      logic [6:0] obs;
      obs = {Stall, pc_write, ifid_write, ifid_flush, idex_flush, freeze, mem_err};
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b required %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   // Check outputs mid-cycle, then advance to the next falling edge.
   task automatic step(input string tag, input logic [6:0] exp);
      #1;
      chk(tag, exp);
      @(negedge clk);
   endtask

   task automatic id_set(input logic v, input logic [4:0] rd, input logic ld, input logic wr,
                         input logic mm, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
      id_valid     = v;
      id_rd        = rd;
      id_load      = ld;
      id_reg_write = wr;
      id_mem       = mm;
      id_rs1       = rs1;
      id_use_rs1   = u1;
      id_rs2       = rs2;
      id_use_rs2   = u2;
   endtask

   task automatic id_none();
      id_set(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      reset_n     = 1'b0;
      ex_redirect = 1'b0;
      dmem_ready  = 1'b1;
      id_none();

      // reset state
      #1;
      chk("reset", NORM);
`ifdef HAZARD_PERF_EN
      chk32("perf_stall_rst", perf_stall_cnt, 32'd0);
      chk32("perf_flush_rst", perf_flush_cnt, 32'd0);
      chk32("perf_freeze_rst", perf_freeze_cnt, 32'd0);
`endif
      @(negedge clk);
      step("reset_held", NORM);
      reset_n = 1'b1;

      // load-use on rs1
      id_set(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
      step("lu_issue", NORM);
      id_set(1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 5'd3, 1'b1);
      step("lu_stall", STALL);
      step("lu_release", NORM);
      id_none();
      step("lu_drain", NORM);

      // rs2 paths and non-load producer
      id_set(1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step("lw7_issue", NORM);
      id_set(1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 5'd7, 1'b0);
      step("rs2_unused", NORM);
      id_set(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
      step("alu_producer", NORM);
      id_set(1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step("lw7_again", NORM);
      id_set(1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
      step("rs2_stall", STALL);
      id_none();
      step("rs2_drain", NORM);

      // rd=x0 and full-width index compare
      id_set(1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step("lw_x0", NORM);
      id_set(1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
      step("x0_no_hazard", NORM);
      id_set(1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step("lw_x9", NORM);
      id_set(1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd25, 1'b1, 5'd25, 1'b1);
      step("full_width", NORM);
      id_none();
      step("fw_drain", NORM);

      // redirect, penalty 2
      id_set(1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      ex_redirect = 1'b1;
      step("redir_c1", FLSH);
      ex_redirect = 1'b0;
      id_set(1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step("redir_c2", FLSH);
      id_set(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
      step("redir_ex_invalid", NORM);
      id_none();
      step("redir_drain", NORM);

      // redirect coinciding with load-use, then reload while flushing
      id_set(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step("lw5_issue", NORM);
      id_set(1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
      ex_redirect = 1'b1;
      step("redir_vs_lu", FLSH);
      id_none();
      step("redir_reload", FLSH);
      ex_redirect = 1'b0;
      step("reload_tail", FLSH);
      #1;
      chk("flush_done", NORM);
`ifdef HAZARD_PERF_EN
      chk32("perf_stall_mid", perf_stall_cnt, 32'd2);
      chk32("perf_flush_mid", perf_flush_cnt, 32'd5);
      chk32("perf_freeze_mid", perf_freeze_cnt, 32'd0);
`endif
      @(negedge clk);

      // memory wait with deferred redirect
      id_set(1'b1, 5'd10, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step("lw10_issue", NORM);
      id_none();
      step("lw10_ex", NORM);
      dmem_ready  = 1'b0;
      ex_redirect = 1'b1;
      step("frz1", FRZ);
      step("frz2", FRZ);
      step("frz3", FRZ);
      dmem_ready = 1'b1;
      step("release_flush", FLSH);
      ex_redirect = 1'b0;
      step("deferred_tail", FLSH);
      step("wait_done", NORM);

      // timeout on a store
      id_set(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
      step("sw_issue", NORM);
      id_none();
      step("sw_ex", NORM);
      dmem_ready = 1'b0;
      step("to_w1", FRZ);
      step("to_w2", FRZ);
      step("to_w3", FRZ);
      step("to_w4_err", FERR);
      step("after_abort", NORM);
      dmem_ready = 1'b1;
      step("abort_idle", NORM);

      // async reset during a memory wait
      id_set(1'b1, 5'd12, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      step("lw12_issue", NORM);
      id_none();
      step("lw12_ex", NORM);
      dmem_ready = 1'b0;
      step("rst_frz1", FRZ);
      step("rst_frz2", FRZ);
      reset_n = 1'b0;
      #1;
      chk("rst_async", NORM);
`ifdef HAZARD_PERF_EN
      chk32("perf_stall_arst", perf_stall_cnt, 32'd0);
      chk32("perf_flush_arst", perf_flush_cnt, 32'd0);
      chk32("perf_freeze_arst", perf_freeze_cnt, 32'd0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      step("post_rst", NORM);
      dmem_ready = 1'b1;
      step("post_rst_idle", NORM);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
